// File: rtl/mem_ab_systolic_pkg.sv
// mem_ab_systolic_pkg: shared sizes for the A/B skew buffers and the systolic array
package mem_ab_systolic_pkg;
  localparam int BITS_AB = 8;
  localparam int BITS_C = 16;
  localparam int DIM = 8;
  localparam int ROWBITS = $clog2(DIM);
endpackage

// File: rtl/mem_ab_systolic_array.sv
// systolic_array: DIM x DIM grid of pe; A flows right from a_edge, B flows down from b_edge
// ports: wr/row/wdata write one C row, c exposes every accumulator
module systolic_array
  import mem_ab_systolic_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [DIM-1:0][BITS_AB-1:0]           a_edge,
  input  logic [DIM-1:0][BITS_AB-1:0]           b_edge,
  input  logic                                  wr,
  input  logic [ROWBITS-1:0]                    row,
  input  logic [DIM-1:0][BITS_C-1:0]            wdata,
  output logic [DIM-1:0][DIM-1:0][BITS_C-1:0]   c
);
  logic [BITS_AB-1:0] ah [DIM][DIM+1];
  logic [BITS_AB-1:0] bv [DIM+1][DIM];
  for (genvar i = 0; i < DIM; i++) begin : g_edge
    assign ah[i][0] = a_edge[i];
    assign bv[0][i] = b_edge[i];
  end
  for (genvar i = 0; i < DIM; i++) begin : g_r
    for (genvar j = 0; j < DIM; j++) begin : g_c
      pe u_pe (
        .clk, .rst_n, .en,
        .wr(wr && row == ROWBITS'(i)),
        .wdata(wdata[j]),
        .a(ah[i][j]),
        .b(bv[i][j]),
        .a_pass(ah[i][j+1]),
        .b_pass(bv[i+1][j]),
        .acc(c[i][j])
      );
    end
  end
endmodule

// File: rtl/mem_ab_systolic_mem_a.sv
// mem_a: row-loaded A skew buffer; row r is a DIM+r stage shift register
// ports: load/row/row_data parallel-load one row, en shifts all rows, a_edge = stage 0 of each row
module mem_a
  import mem_ab_systolic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [ROWBITS-1:0]            row,
  input  logic [DIM-1:0][BITS_AB-1:0]   row_data,
  output logic [DIM-1:0][BITS_AB-1:0]   a_edge
);
  for (genvar r = 0; r < DIM; r++) begin : g_row
    logic [BITS_AB-1:0] sr [DIM+r];
    // r leading zeros at the output end give row r its r-cycle skew
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int s = 0; s < DIM + r; s++) sr[s] <= '0;
      end else if (load) begin
        if (row == ROWBITS'(r)) begin
          for (int s = 0; s < r; s++) sr[s] <= '0;
          for (int s = 0; s < DIM; s++) sr[r+s] <= row_data[s];
        end
      end else if (en) begin
        for (int s = 0; s < DIM + r - 1; s++) sr[s] <= sr[s+1];
        sr[DIM+r-1] <= '0;
      end
    assign a_edge[r] = sr[0];
  end
endmodule

// File: rtl/mem_ab_systolic_mem_b.sv
// mem_b: column-skewing B delay buffer; column c is a DIM+c stage shift register
// ports: col_data enters stage 0 on en, b_edge = last stage of each column
module mem_b
  import mem_ab_systolic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIM-1:0][BITS_AB-1:0]   col_data,
  output logic [DIM-1:0][BITS_AB-1:0]   b_edge
);
  for (genvar c = 0; c < DIM; c++) begin : g_col
    logic [BITS_AB-1:0] sr [DIM+c];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int s = 0; s < DIM + c; s++) sr[s] <= '0;
      end else if (en) begin
        sr[0] <= col_data[c];
        for (int s = 1; s < DIM + c; s++) sr[s] <= sr[s-1];
      end
    assign b_edge[c] = sr[DIM+c-1];
  end
endmodule

// File: rtl/mem_ab_systolic_pe.sv
// pe: output-stationary MAC cell with registered a/b pass-through
// ports: a/b operands in, a_pass/b_pass to right/lower neighbour, acc accumulator, wr/wdata overwrite acc
module pe
  import mem_ab_systolic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               wr,
  input  logic [BITS_C-1:0]  wdata,
  input  logic [BITS_AB-1:0] a,
  input  logic [BITS_AB-1:0] b,
  output logic [BITS_AB-1:0] a_pass,
  output logic [BITS_AB-1:0] b_pass,
  output logic [BITS_C-1:0]  acc
);
  logic signed [2*BITS_AB-1:0] prod;
  assign prod = $signed(a) * $signed(b);
  // host write wins over accumulation; sum wraps at BITS_C
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_pass <= '0;
      b_pass <= '0;
      acc <= '0;
    end else begin
      if (en) begin
        a_pass <= a;
        b_pass <= b;
      end
      if (wr) acc <= wdata;
      else if (en) acc <= acc + BITS_C'(prod);
    end
endmodule

// File: rtl/mem_ab_systolic.sv
// mem_ab_systolic: A/B skew buffers feeding an output-stationary systolic array, C += A*B
// ports: WrEnA/Arow/Ain load A rows, Bin streams B rows, WrEnC/Crow/Cin write C, Cout reads C row Crow,
//        Aout/Bout show the array edge operands
module mem_ab_systolic
  import mem_ab_systolic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          WrEnA,
  input  logic [ROWBITS-1:0]            Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]   Ain,
  input  logic [DIM-1:0][BITS_AB-1:0]   Bin,
  input  logic                          WrEnC,
  input  logic [ROWBITS-1:0]            Crow,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic [DIM-1:0][BITS_C-1:0]    Cout,
  output logic [DIM-1:0][BITS_AB-1:0]   Aout,
  output logic [DIM-1:0][BITS_AB-1:0]   Bout
);
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0] c;
  mem_a u_mem_a (.clk, .rst_n, .en, .load(WrEnA), .row(Arow), .row_data(Ain), .a_edge(Aout));
  mem_b u_mem_b (.clk, .rst_n, .en, .col_data(Bin), .b_edge(Bout));
  systolic_array u_array (
    .clk, .rst_n, .en,
    .a_edge(Aout), .b_edge(Bout),
    .wr(WrEnC), .row(Crow), .wdata(Cin),
    .c
  );
  assign Cout = c[Crow];
endmodule

// File: tb/tb_mem_ab_systolic.sv
// tb_mem_ab_systolic: directed self-checking bench for mem_ab_systolic
module tb_mem_ab_systolic;
  import mem_ab_systolic_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic en = 0;
  logic WrEnA = 0;
  logic WrEnC = 0;
  logic [ROWBITS-1:0] Arow = '0;
  logic [ROWBITS-1:0] Crow = '0;
  logic [DIM-1:0][BITS_AB-1:0] Ain = '0;
  logic [DIM-1:0][BITS_AB-1:0] Bin = '0;
  logic [DIM-1:0][BITS_C-1:0] Cin = '0;
  logic [DIM-1:0][BITS_C-1:0] Cout;
  logic [DIM-1:0][BITS_AB-1:0] Aout;
  logic [DIM-1:0][BITS_AB-1:0] Bout;
  int errors = 0;
  int checks = 0;
  logic [BITS_AB-1:0] ma [DIM][DIM];
  logic [BITS_AB-1:0] mb [DIM][DIM];
  logic [BITS_C-1:0] mc [DIM][DIM];

  always #5 clk = ~clk;

  mem_ab_systolic dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEnA(WrEnA), .Arow(Arow), .Ain(Ain), .Bin(Bin),
    .WrEnC(WrEnC), .Crow(Crow), .Cin(Cin), .Cout(Cout), .Aout(Aout), .Bout(Bout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input int r, output logic [DIM-1:0][BITS_C-1:0] v);
    Crow = ROWBITS'(r);
    #1;
    v = Cout;
  endtask

  function automatic logic [DIM-1:0][BITS_C-1:0] model_row(input int r);
    logic [DIM-1:0][BITS_C-1:0] v;
    for (int j = 0; j < DIM; j++) v[j] = mc[r][j];
    return v;
  endfunction

  task automatic clear_c();
    en = 0;
    Cin = '0;
    for (int r = 0; r < DIM; r++) begin
      WrEnC = 1;
      Crow = ROWBITS'(r);
      step();
    end
    WrEnC = 0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mc[i][j] = '0;
  endtask

  task automatic load();
    int acc;
    for (int r = 0; r < DIM; r++) begin
      en = 1;
      WrEnA = 1;
      Arow = ROWBITS'(r);
      for (int c = 0; c < DIM; c++) begin
        Ain[c] = ma[r][c];
        Bin[c] = mb[r][c];
      end
      step();
    end
    WrEnA = 0;
    Ain = '0;
    Bin = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        acc = 0;
        for (int k = 0; k < DIM; k++)
          acc += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
        mc[i][j] = mc[i][j] + BITS_C'(acc);
      end
  endtask

  task automatic run(input int n);
    en = 1;
    repeat (n) step();
    en = 0;
  endtask

  task automatic set_identity_pattern();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = BITS_AB'(r * DIM + c);
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = BITS_AB'($urandom);
        mb[r][c] = BITS_AB'($urandom);
      end
  endtask

  task automatic test_reset();
    logic [DIM-1:0][BITS_C-1:0] v;
    rst_n = 0;
    #2;
    checks++;
    if (Aout !== '0 || Bout !== '0) begin
      errors++;
      $display("FAIL reset_ab Aout=%h Bout=%h want 0", Aout, Bout);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r, v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL reset_c row %0d got %h want 0", r, v);
      end
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_zero();
    logic [DIM-1:0][BITS_C-1:0] v;
    Ain = '0;
    Bin = '0;
    run(DIM);
    checks++;
    if (Aout !== '0 || Bout !== '0) begin
      errors++;
      $display("FAIL zero_ab Aout=%h Bout=%h want 0", Aout, Bout);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r, v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL zero_c row %0d got %h want 0", r, v);
      end
    end
  endtask

  task automatic test_identity();
    logic [DIM-1:0][BITS_C-1:0] v, e;
    clear_c();
    set_identity_pattern();
    load();
    run(3 * DIM);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) e[c] = BITS_C'(r * DIM + c);
      read_row(r, v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL identity row %0d got %h want %h", r, v, e);
      end
    end
  endtask

  task automatic test_skew();
    logic [DIM-1:0][BITS_AB-1:0] ea, eb;
    logic [DIM-1:0][BITS_C-1:0] v;
    int idx;
    clear_c();
    set_random();
    load();
    for (int k = 0; k < 3 * DIM; k++) begin
      for (int r = 0; r < DIM; r++) begin
        idx = k - r;
        ea[r] = (idx >= 0 && idx < DIM) ? ma[r][idx] : '0;
        eb[r] = (idx >= 0 && idx < DIM) ? mb[idx][r] : '0;
      end
      @(negedge clk);
      checks++;
      if (Aout !== ea || Bout !== eb) begin
        errors++;
        $display("FAIL skew k=%0d Aout=%h want %h Bout=%h want %h", k, Aout, ea, Bout, eb);
      end
      en = 1;
      step();
    end
    en = 0;
    for (int r = 0; r < DIM; r++) begin
      read_row(r, v);
      checks++;
      if (v !== model_row(r)) begin
        errors++;
        $display("FAIL skew_c row %0d got %h want %h", r, v, model_row(r));
      end
    end
  endtask

  task automatic test_random();
    logic [DIM-1:0][BITS_C-1:0] v;
    for (int it = 0; it < 20; it++) begin
      clear_c();
      set_random();
      load();
      run(3 * DIM);
      for (int r = 0; r < DIM; r++) begin
        read_row(r, v);
        checks++;
        if (v !== model_row(r)) begin
          errors++;
          $display("FAIL random it=%0d row %0d got %h want %h", it, r, v, model_row(r));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [DIM-1:0][BITS_C-1:0] v, e;
    clear_c();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = 8'd127;
        mb[r][c] = 8'd127;
      end
    load();
    run(3 * DIM);
    for (int c = 0; c < DIM; c++) e[c] = 16'hF808;
    for (int r = 0; r < DIM; r++) begin
      read_row(r, v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL overflow row %0d got %h want %h", r, v, e);
      end
    end
  endtask

  task automatic test_cwrite();
    logic [DIM-1:0][BITS_C-1:0] v, e;
    en = 0;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) begin
        Cin[j] = BITS_C'(100 * r + j);
        mc[r][j] = BITS_C'(100 * r + j);
      end
      WrEnC = 1;
      Crow = ROWBITS'(r);
      step();
    end
    WrEnC = 0;
    Cin = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) e[j] = BITS_C'(100 * r + j);
      read_row(r, v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL cwrite row %0d got %h want %h", r, v, e);
      end
    end
    set_identity_pattern();
    load();
    run(3 * DIM);
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) e[j] = BITS_C'(100 * r + j + r * DIM + j);
      read_row(r, v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL cwrite_acc row %0d got %h want %h", r, v, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DIM-1:0][BITS_C-1:0] v;
    clear_c();
    set_random();
    ma[0][0] = 8'd3;
    load();
    run(5);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (Aout !== '0 || Bout !== '0) begin
      errors++;
      $display("FAIL async_reset_ab Aout=%h Bout=%h want 0", Aout, Bout);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r, v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL async_reset_c row %0d got %h want 0", r, v);
      end
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_identity();
    test_skew();
    test_random();
    test_overflow();
    test_cwrite();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
